// File: rtl/usb_ep_stream_bridge_if.sv
// Signal bundle between the USB PE endpoint pair, the byte streams and usb_ep_stream_bridge.
// master = bridge side, slave = PE/stream environment side.
interface usb_ep_stream_bridge_if #(
  parameter int TIMEOUT_W = 8
);
  logic                 o_outEp_req;
  logic                 i_outEp_grant;
  logic                 i_outEp_dataAvail;
  logic                 o_outEp_dataGet;
  logic [7:0]           i_outEp_data;
  logic                 o_inEp_req;
  logic                 i_inEp_grant;
  logic                 i_inEp_dataFree;
  logic                 o_inEp_dataPut;
  logic [7:0]           o_inEp_data;
  logic                 o_inEp_dataDone;
  logic                 o_inEp_stall;
  logic                 i_inEp_acked;
  logic [TIMEOUT_W-1:0] i_timeout;
  logic [7:0]           i_in_data;
  logic                 i_in_valid;
  logic                 o_in_ready;
  logic [7:0]           o_out_data;
  logic                 o_out_valid;
  logic                 i_out_ready;

  modport master (
    output o_outEp_req, o_outEp_dataGet, o_inEp_req, o_inEp_dataPut, o_inEp_data,
           o_inEp_dataDone, o_inEp_stall, o_in_ready, o_out_data, o_out_valid,
    input  i_outEp_grant, i_outEp_dataAvail, i_outEp_data, i_inEp_grant, i_inEp_dataFree,
           i_inEp_acked, i_timeout, i_in_data, i_in_valid, i_out_ready
  );

  modport slave (
    input  o_outEp_req, o_outEp_dataGet, o_inEp_req, o_inEp_dataPut, o_inEp_data,
           o_inEp_dataDone, o_inEp_stall, o_in_ready, o_out_data, o_out_valid,
    output i_outEp_grant, i_outEp_dataAvail, i_outEp_data, i_inEp_grant, i_inEp_dataFree,
           i_inEp_acked, i_timeout, i_in_data, i_in_valid, i_out_ready
  );
endinterface

// File: rtl/usb_ep_stream_bridge.sv
// Bridges a USB OUT/IN endpoint pair to byte streams through FIFOs; IN packets close on size or idle timeout.
// Define USB_EP_BRIDGE_ZLP_EN to send a zero-length packet after a full-size packet that is not followed by data.
module usb_ep_stream_bridge #(
  parameter int OUT_DEPTH = 8,
  parameter int IN_DEPTH  = 16,
  parameter int MAX_PKT   = 32,
  parameter int TIMEOUT_W = 8
) (
  input logic                    i_clk,
  input logic                    i_rst,
  usb_ep_stream_bridge_if.master bus
);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int PW  = $clog2(MAX_PKT + 1);
  localparam logic [OAW:0]          OINC    = 1;
  localparam logic [IAW:0]          IINC    = 1;
  localparam logic [PW-1:0]         PINC    = 1;
  localparam logic [PW-1:0]         MAX_CNT = PW'(MAX_PKT);
  localparam logic [TIMEOUT_W-1:0]  TINC    = 1;
`ifdef USB_EP_BRIDGE_ZLP_EN
  localparam bit ZLP_EN = 1'b1;
`else
  localparam bit ZLP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {O_IDLE, O_REQ, O_GET} out_st_e;
  typedef enum logic [2:0] {I_IDLE, I_REQ, I_FILL, I_DONE, I_WAITACK} in_st_e;

  out_st_e out_st_q, out_st_d;
  in_st_e  in_st_q, in_st_d;

  logic [7:0]           out_mem [OUT_DEPTH];
  logic [7:0]           in_mem  [IN_DEPTH];
  logic [OAW:0]         out_wr_q, out_rd_q;
  logic [IAW:0]         in_wr_q, in_rd_q;
  logic                 out_full, out_empty, in_full, in_empty;
  logic                 out_push, out_pop, in_push, in_pop, in_rdy;
  logic                 get, put;
  logic                 rdy_en_q;
  logic [PW-1:0]        pkt_cnt_q, pkt_cnt_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 zlp_q, zlp_d;

  // FIFO status: pointers carry one wrap bit beyond the address
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[OAW] != out_rd_q[OAW]) && (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);
  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[IAW] != in_rd_q[IAW]) && (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);

  assign out_push = get;
  assign out_pop  = !out_empty && bus.i_out_ready;
  assign in_rdy   = rdy_en_q && !in_full;
  assign in_push  = bus.i_in_valid && in_rdy;
  assign in_pop   = put;

  assign bus.o_out_valid  = !out_empty;
  assign bus.o_out_data   = out_empty ? 8'h00 : out_mem[out_rd_q[OAW-1:0]];
  assign bus.o_in_ready   = in_rdy;
  assign bus.o_inEp_data  = in_empty ? 8'h00 : in_mem[in_rd_q[IAW-1:0]];
  assign bus.o_inEp_stall = 1'b0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_wr_q <= '0;
      out_rd_q <= '0;
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      if (out_push) out_wr_q <= out_wr_q + OINC;
      if (out_pop)  out_rd_q <= out_rd_q + OINC;
      if (in_push)  in_wr_q  <= in_wr_q + IINC;
      if (in_pop)   in_rd_q  <= in_rd_q + IINC;
      rdy_en_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (out_push) out_mem[out_wr_q[OAW-1:0]] <= bus.i_outEp_data;
    if (in_push)  in_mem[in_wr_q[IAW-1:0]]   <= bus.i_in_data;
  end

  // OUT endpoint FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) out_st_q <= O_IDLE;
    else       out_st_q <= out_st_d;
  end

  always_comb begin
    out_st_d = out_st_q;
    case (out_st_q)
      O_IDLE:  if (bus.i_outEp_dataAvail) out_st_d = O_REQ;
      O_REQ:   if (bus.i_outEp_grant) out_st_d = O_GET;
      O_GET:   if (!bus.i_outEp_dataAvail) out_st_d = O_IDLE;
      default: out_st_d = O_IDLE;
    endcase
  end

  // Holding req while the FIFO is full keeps the host buffer owned until space frees
  always_comb begin
    bus.o_outEp_req     = (out_st_q != O_IDLE);
    get                 = (out_st_q == O_GET) && bus.i_outEp_grant &&
                          bus.i_outEp_dataAvail && !out_full;
    bus.o_outEp_dataGet = get;
  end

  // IN endpoint FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_st_q   <= I_IDLE;
      pkt_cnt_q <= '0;
      timer_q   <= '0;
      zlp_q     <= 1'b0;
    end else begin
      in_st_q   <= in_st_d;
      pkt_cnt_q <= pkt_cnt_d;
      timer_q   <= timer_d;
      zlp_q     <= zlp_d;
    end
  end

  always_comb begin
    in_st_d   = in_st_q;
    pkt_cnt_d = pkt_cnt_q;
    timer_d   = timer_q;
    zlp_d     = zlp_q;
    case (in_st_q)
      I_IDLE: if (bus.i_inEp_dataFree && (!in_empty || zlp_q)) in_st_d = I_REQ;
      I_REQ: begin
        if (bus.i_inEp_grant) begin
          in_st_d   = I_FILL;
          pkt_cnt_d = '0;
          timer_d   = '0;
        end
      end
      I_FILL: begin
        if (put) begin
          pkt_cnt_d = pkt_cnt_q + PINC;
          timer_d   = '0;
        end else if (in_empty && (timer_q != '1)) begin
          timer_d = timer_q + TINC;
        end
        // Max-size close wins over the timeout; a pending ZLP closes an empty packet
        if (put && (pkt_cnt_q + PINC == MAX_CNT)) begin
          in_st_d = I_DONE;
          zlp_d   = ZLP_EN;
        end else if (!bus.i_inEp_dataFree && (pkt_cnt_q != '0)) begin
          in_st_d = I_DONE;
        end else if (in_empty && (timer_q >= bus.i_timeout) && ((pkt_cnt_q != '0) || zlp_q)) begin
          in_st_d = I_DONE;
        end
      end
      I_DONE: in_st_d = I_WAITACK;
      I_WAITACK: begin
        if (bus.i_inEp_acked) begin
          in_st_d = I_IDLE;
          zlp_d   = ZLP_EN && (pkt_cnt_q == MAX_CNT);
        end
      end
      default: in_st_d = I_IDLE;
    endcase
  end

  always_comb begin
    bus.o_inEp_req      = (in_st_q == I_REQ) || (in_st_q == I_FILL) || (in_st_q == I_DONE);
    put                 = (in_st_q == I_FILL) && bus.i_inEp_grant &&
                          bus.i_inEp_dataFree && !in_empty;
    bus.o_inEp_dataPut  = put;
    bus.o_inEp_dataDone = (in_st_q == I_DONE);
  end
endmodule

// File: tb/tb_usb_ep_stream_bridge.sv
// Bench for usb_ep_stream_bridge: PE host models on both endpoints, byte scoreboards and packet-size scoreboard.
module tb_usb_ep_stream_bridge;
  localparam int TW      = 8;
  localparam int TIMEOUT = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  usb_ep_stream_bridge_if #(.TIMEOUT_W(TW)) bus ();

  usb_ep_stream_bridge #(
    .OUT_DEPTH(8), .IN_DEPTH(16), .MAX_PKT(32), .TIMEOUT_W(TW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] host_q[$];
  logic [7:0] exp_out[$];
  logic [7:0] src_q[$];
  logic [7:0] exp_in[$];
  int exp_pkt[$];
  int out_req_cnt = 0, get_cnt = 0, put_cnt = 0, cur_pkt = 0, pkt_seen = 0;
  int last_put_cyc = 0, last_done_cyc = 0, ack_cnt = 0;
  bit out_ready = 1'b1, in_free = 1'b1, in_grant_en = 1'b1, stop_grant_on_put = 1'b0;
  int base_get, base_put, base_pkt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    bus.i_outEp_dataAvail = (host_q.size() != 0);
    bus.i_outEp_data      = (host_q.size() != 0) ? host_q[0] : 8'h00;
    bus.i_outEp_grant     = bus.o_outEp_req && (out_req_cnt >= 2);
    bus.i_out_ready       = out_ready;
    bus.i_inEp_grant      = bus.o_inEp_req && in_grant_en;
    bus.i_inEp_dataFree   = in_free;
    bus.i_inEp_acked      = (ack_cnt == 1);
    bus.i_in_valid        = (src_q.size() != 0);
    bus.i_in_data         = (src_q.size() != 0) ? src_q[0] : 8'h00;
    bus.i_timeout         = TW'(TIMEOUT);
  endtask

  task automatic sample();
    if (bus.o_outEp_dataGet) begin
      get_cnt++;
      if (host_q.size() != 0) void'(host_q.pop_front());
    end
    if (bus.o_out_valid && bus.i_out_ready) begin
      if (exp_out.size() == 0) check_eq("out_unexpected", 32'(exp_out.size()), 1);
      else check_eq("out_data", bus.o_out_data, exp_out.pop_front());
    end
    if (bus.o_in_ready && bus.i_in_valid) void'(src_q.pop_front());
    if (bus.o_inEp_dataPut) begin
      if (exp_in.size() == 0) check_eq("in_unexpected", 32'(exp_in.size()), 1);
      else check_eq("in_data", bus.o_inEp_data, exp_in.pop_front());
      cur_pkt++;
      put_cnt++;
      last_put_cyc = cyc;
      if (stop_grant_on_put) in_grant_en = 1'b0;
    end
    if (bus.o_inEp_dataDone) begin
      pkt_seen++;
      last_done_cyc = cyc;
      if (exp_pkt.size() == 0) check_eq("pkt_unexpected", 32'(exp_pkt.size()), 1);
      else check_eq("pkt_len", cur_pkt, exp_pkt.pop_front());
      cur_pkt = 0;
      ack_cnt = 4;
    end else if (ack_cnt > 0) begin
      ack_cnt--;
    end
    out_req_cnt = bus.o_outEp_req ? out_req_cnt + 1 : 0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_inputs();
      #1;
      sample();
      cyc++;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.o_outEp_req, bus.o_outEp_dataGet, bus.o_inEp_req, bus.o_inEp_dataPut,
            bus.o_inEp_dataDone, bus.o_inEp_stall, bus.o_in_ready, bus.o_out_valid,
            bus.o_inEp_data, bus.o_out_data};
  endfunction

  initial begin
    drive_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", all_outs(), 32'h0);
    rst = 1'b0;
    run_cycles(2);
    check_eq("reset_in_ready", bus.o_in_ready, 1);
    check_eq("reset_idle_req", {bus.o_outEp_req, bus.o_inEp_req}, 2'b00);

    // OUT transfer of 5 bytes
    base_get = get_cnt;
    for (int i = 0; i < 5; i++) begin
      host_q.push_back(8'(8'hA0 + i));
      exp_out.push_back(8'(8'hA0 + i));
    end
    run_cycles(30);
    check_eq("t1_gets", get_cnt - base_get, 5);
    check_eq("t1_drained", 32'(exp_out.size()), 0);
    check_eq("t1_req_dropped", bus.o_outEp_req, 0);

    // OUT FIFO full with the stream stalled
    out_ready = 1'b0;
    base_get = get_cnt;
    for (int i = 0; i < 12; i++) begin
      host_q.push_back(8'(8'h30 + 3 * i));
      exp_out.push_back(8'(8'h30 + 3 * i));
    end
    run_cycles(30);
    check_eq("t2_gets_at_full", get_cnt - base_get, 8);
    check_eq("t2_req_held", bus.o_outEp_req, 1);
    check_eq("t2_get_blocked", bus.o_outEp_dataGet, 0);
    out_ready = 1'b1;
    run_cycles(60);
    check_eq("t2_gets_total", get_cnt - base_get, 12);
    check_eq("t2_drained", 32'(exp_out.size()), 0);
    check_eq("t2_req_dropped", bus.o_outEp_req, 0);

    // IN packet closed by timeout
    base_put = put_cnt;
    base_pkt = pkt_seen;
    for (int i = 0; i < 3; i++) begin
      src_q.push_back(8'(8'h51 + i));
      exp_in.push_back(8'(8'h51 + i));
    end
    exp_pkt.push_back(3);
    run_cycles(50);
    check_eq("t3_puts", put_cnt - base_put, 3);
    check_eq("t3_pkts", pkt_seen - base_pkt, 1);
    check_eq("t3_timeout_gap", last_done_cyc - last_put_cyc, TIMEOUT + 2);
    check_eq("t3_idle", bus.o_inEp_req, 0);

    // IN max-size packet followed by a short packet
    base_put = put_cnt;
    base_pkt = pkt_seen;
    for (int i = 0; i < 40; i++) begin
      src_q.push_back(8'($urandom_range(0, 255)));
      exp_in.push_back(src_q[$]);
    end
    exp_pkt.push_back(32);
    exp_pkt.push_back(8);
    run_cycles(150);
    check_eq("t4_puts", put_cnt - base_put, 40);
    check_eq("t4_pkts", pkt_seen - base_pkt, 2);
    check_eq("t4_timeout_gap", last_done_cyc - last_put_cyc, TIMEOUT + 2);
    check_eq("t4_in_drained", 32'(exp_in.size()), 0);

    // Exactly MAX_PKT bytes: ZLP only when enabled
    base_put = put_cnt;
    base_pkt = pkt_seen;
    for (int i = 0; i < 32; i++) begin
      src_q.push_back(8'(8'hC0 ^ i));
      exp_in.push_back(8'(8'hC0 ^ i));
    end
    exp_pkt.push_back(32);
`ifdef USB_EP_BRIDGE_ZLP_EN
    exp_pkt.push_back(0);
    run_cycles(150);
    check_eq("t5_pkts", pkt_seen - base_pkt, 2);
`else
    run_cycles(150);
    check_eq("t5_pkts", pkt_seen - base_pkt, 1);
`endif
    check_eq("t5_puts", put_cnt - base_put, 32);
    check_eq("t5_idle", bus.o_inEp_req, 0);

    // Reset in the middle of an IN packet with bytes still queued
    base_put = put_cnt;
    base_pkt = pkt_seen;
    stop_grant_on_put = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src_q.push_back(8'(8'h11 * (i + 1)));
      exp_in.push_back(8'(8'h11 * (i + 1)));
    end
    run_cycles(20);
    check_eq("t6_one_put", put_cnt - base_put, 1);
    check_eq("t6_in_fill", bus.o_inEp_req, 1);
    check_eq("t6_queued", bus.o_out_valid == 1'b0 && bus.o_inEp_data != 8'h00, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_reset_outputs", all_outs(), 32'h0);
    src_q.delete();
    exp_in.delete();
    exp_pkt.delete();
    cur_pkt = 0;
    ack_cnt = 0;
    in_grant_en = 1'b1;
    stop_grant_on_put = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_cycles(30);
    check_eq("t6_in_ready", bus.o_in_ready, 1);
    check_eq("t6_no_done", pkt_seen - base_pkt, 0);
    check_eq("t6_idle", {bus.o_inEp_req, bus.o_inEp_dataPut}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
